spi_peripheral: RTL and testbench

- SPI responder: the far end of the team's 16-bit SPI master, used on the slave-side FPGA/board link.
- Oversamples sclk, cs and mosi in the local clk domain. Deserialises 16-bit LSB-first frames from mosi and serialises a 16-bit response on miso.
- Presents each received word to local logic with a one-cycle valid strobe.

---
 rtl/spi_peripheral.sv | 138 +++++++++++++
 tb/tb_spi_peripheral.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI responder: oversamples sclk/cs/mosi in the local clock domain, receives
// LSB-first words on mosi and returns a response word on miso.
module spi_peripheral #(
   parameter int   DATA_WIDTH  = 16,
   parameter logic CS_ACTIVE   = 1'b0,
   parameter logic CPOL        = 1'b0,
   parameter int   SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_sclk,
   input  logic                  i_cs,
   input  logic                  i_mosi,
   output logic                  o_miso,
   input  logic [DATA_WIDTH-1:0] i_data_to_tx,
   output logic [DATA_WIDTH-1:0] o_data_rx,
   output logic                  o_rx_valid,
   output logic                  o_tx_loaded,
   output logic                  o_busy,
   output logic                  o_frame_error
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0]  r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                    r_sclk_d, r_cs_d;
   logic [DATA_WIDTH-1:0]   r_rx_shift, r_tx_shift, r_data_rx;
   logic [CW-1:0]           r_bit_cnt, w_cnt_after;
   logic                    r_miso, r_rx_valid, r_tx_loaded, r_frame_err;
   logic                    w_sclk_s, w_cs_s, w_mosi_s;
   logic                    w_sclk_trail, w_cs_on, w_cs_off, w_wrap;
   logic [DATA_WIDTH-1:0]   w_rx_next;

   // Chains preset to the idle pin levels so reset release never looks like an edge
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_sclk_sync <= {SYNC_STAGES{CPOL}};
         r_cs_sync   <= {SYNC_STAGES{~CS_ACTIVE}};
         r_mosi_sync <= '0;
         r_sclk_d    <= CPOL;
         r_cs_d      <= ~CS_ACTIVE;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_sclk_d    <= w_sclk_s;
         r_cs_d      <= w_cs_s;
      end
   end

   assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_trail = (w_sclk_s == CPOL) && (r_sclk_d != CPOL);
   assign w_cs_on      = (w_cs_s == CS_ACTIVE) && (r_cs_d != CS_ACTIVE);
   assign w_cs_off     = (w_cs_s != CS_ACTIVE) && (r_cs_d == CS_ACTIVE);
   assign w_rx_next    = {w_mosi_s, r_rx_shift[DATA_WIDTH-1:1]};
   assign w_wrap       = w_sclk_trail && (r_bit_cnt == LAST);

   // Bit count as it stands after this cycle's sclk edge; cs is judged against it
   always_comb begin
      w_cnt_after = r_bit_cnt;
      if (w_sclk_trail) w_cnt_after = w_wrap ? '0 : r_bit_cnt + 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_cs_on)  w_state_nxt = SHIFT;
         SHIFT:   if (w_cs_off) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_data_rx   <= '0;
         r_bit_cnt   <= '0;
         r_miso      <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_tx_loaded <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_tx_loaded <= 1'b0;
         r_frame_err <= 1'b0;
         if (r_state == IDLE) begin
            if (w_cs_on) begin
               r_tx_shift  <= i_data_to_tx;
               r_miso      <= i_data_to_tx[0];
               r_tx_loaded <= 1'b1;
               r_bit_cnt   <= '0;
            end
         end else begin
            if (w_sclk_trail) begin
               r_rx_shift <= w_rx_next;
               if (w_wrap) begin
                  r_data_rx   <= w_rx_next;
                  r_rx_valid  <= 1'b1;
                  r_bit_cnt   <= '0;
                  r_tx_shift  <= i_data_to_tx;
                  r_miso      <= i_data_to_tx[0];
                  r_tx_loaded <= 1'b1;
               end else begin
                  r_bit_cnt  <= r_bit_cnt + 1'b1;
                  r_tx_shift <= r_tx_shift >> 1;
                  r_miso     <= r_tx_shift[1];
               end
            end
            // cs release is applied after the sclk edge of the same cycle
            if (w_cs_off) begin
               r_frame_err <= (w_cnt_after != '0);
               r_bit_cnt   <= '0;
               r_miso      <= 1'b0;
            end
         end
      end
   end

   assign o_miso        = r_miso;
   assign o_data_rx     = r_data_rx;
   assign o_rx_valid    = r_rx_valid;
   assign o_tx_loaded   = r_tx_loaded;
   assign o_frame_error = r_frame_err;
   assign o_busy        = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: the bench acts as an SPI master (CPOL=0, active-low
// cs, sclk = clk/10) and checks received/returned words against the sent ones.
module tb_spi_peripheral;

   logic        clk, rst_n, sclk, cs, mosi;
   logic [15:0] din;
   wire         miso, rx_valid, tx_loaded, busy, frame_error;
   wire  [15:0] data_rx;

   spi_peripheral #(.DATA_WIDTH(16), .CS_ACTIVE(1'b0), .CPOL(1'b0), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_sclk(sclk), .i_cs(cs), .i_mosi(mosi),
      .o_miso(miso), .i_data_to_tx(din), .o_data_rx(data_rx), .o_rx_valid(rx_valid),
      .o_tx_loaded(tx_loaded), .o_busy(busy), .o_frame_error(frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse monitor: every high cycle counts, so a stretched pulse is caught
   int          n_rx = 0, n_txl = 0, n_fe = 0;
   logic [15:0] rx_log [256];
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_log[n_rx % 256] = data_rx;
         n_rx++;
      end
      if (tx_loaded)   n_txl++;
      if (frame_error) n_fe++;
   end

   logic [15:0] mo_w [4];   // words the master sends
   logic [15:0] so_w [4];   // response words offered to the responder
   logic [15:0] mi_w [4];   // words decoded from miso

   // mode 0: normal end, 1: cs released together with the last sclk edge,
   // 2: reset asserted after stop_bits while cs is still active
   task automatic frame(input int nw, input int stop_bits, input int mode);
      int total, k, i;
      total = (stop_bits >= 0) ? stop_bits : nw * 16;
      din = so_w[0];
      cs  = 1'b0;
      tick(5);
      for (int b = 0; b < total; b++) begin
         k = b / 16;
         i = b % 16;
         mosi = mo_w[k][i];
         mi_w[k][i] = miso;
         sclk = 1'b1;
         tick(2);
         if (b == 3) chk("busy_mid", {31'd0, busy}, 32'd1);
         if (i == 8) din = (k + 1 < nw) ? so_w[k+1] : 16'($urandom);
         tick(3);
         sclk = 1'b0;
         if (b == total - 1 && mode == 1) cs = 1'b1;
         tick(5);
      end
      if (mode == 2) begin
         rst_n = 1'b0;
         tick(1);
         chk("rst_abort_out", {busy, miso, rx_valid, tx_loaded, frame_error, data_rx}, 32'd0);
         tick(2);
         cs = 1'b1;
         tick(3);
         rst_n = 1'b1;
      end else begin
         cs = 1'b1;
      end
      mosi = 1'($urandom);
      tick(10);
   endtask

   // sclk/mosi activity with cs inactive must be ignored
   task automatic idle_noise(input int n);
      cs = 1'b1;
      for (int j = 0; j < n; j++) begin
         sclk = 1'($urandom);
         mosi = 1'($urandom);
         din  = 16'($urandom);
         tick(2);
      end
      sclk = 1'b0;
      tick(4);
   endtask

   task automatic run_and_check(input string tag, input int nw);
      int b_rx, b_txl, b_fe;
      b_rx = n_rx; b_txl = n_txl; b_fe = n_fe;
      frame(nw, -1, 0);
      chk({tag, "_rx_cnt"}, n_rx - b_rx, nw);
      for (int j = 0; j < nw; j++) begin
         chk({tag, "_rx_word"}, {16'd0, rx_log[(b_rx + j) % 256]}, {16'd0, mo_w[j]});
         chk({tag, "_miso_word"}, {16'd0, mi_w[j]}, {16'd0, so_w[j]});
      end
      chk({tag, "_tx_loaded"}, n_txl - b_txl, nw + 1);
      chk({tag, "_no_ferr"}, n_fe - b_fe, 0);
      chk({tag, "_idle"}, {30'd0, busy, miso}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int b_rx, b_txl, b_fe, nw;
      rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; din = '0;
      tick(2);
      b_rx = n_rx; b_txl = n_txl; b_fe = n_fe;
      for (int j = 0; j < 20; j++) begin
         cs = 1'($urandom); sclk = 1'($urandom); mosi = 1'($urandom); din = 16'($urandom);
         tick(1);
         chk("reset_out", {busy, miso, rx_valid, tx_loaded, frame_error, data_rx}, 32'd0);
      end
      cs = 1'b1; sclk = 1'b0;
      tick(4);
      rst_n = 1'b1;
      tick(10);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);
      chk("post_reset_pulses", (n_rx - b_rx) + (n_txl - b_txl) + (n_fe - b_fe), 0);

      mo_w[0] = 16'hA5C3; so_w[0] = 16'h1234;
      run_and_check("single", 1);

      mo_w[0] = 16'h0001; mo_w[1] = 16'h8000; so_w[0] = 16'h5A5A; so_w[1] = 16'hBEEF;
      run_and_check("two_words", 2);

      mo_w[0] = 16'h0F0F; so_w[0] = 16'h0F0F;
      run_and_check("good_before_err", 1);
      b_rx = n_rx; b_txl = n_txl; b_fe = n_fe;
      mo_w[0] = 16'hFFFF;
      frame(1, 7, 0);
      chk("partial_ferr", n_fe - b_fe, 1);
      chk("partial_no_rx", n_rx - b_rx, 0);
      chk("partial_data_hold", {16'd0, data_rx}, 32'h0F0F);
      chk("partial_tx_loaded", n_txl - b_txl, 1);

      b_rx = n_rx; b_fe = n_fe;
      mo_w[0] = 16'hFFFF;
      frame(1, 9, 2);
      chk("abort_no_pulse", (n_rx - b_rx) + (n_fe - b_fe), 0);
      chk("abort_data_rx", {16'd0, data_rx}, 32'd0);
      mo_w[0] = 16'h5555; so_w[0] = 16'h3C3C;
      run_and_check("after_abort", 1);

      b_rx = n_rx; b_fe = n_fe;
      mo_w[0] = 16'h6B2D; so_w[0] = 16'h0F1E;
      frame(1, -1, 1);
      chk("simul_rx_cnt", n_rx - b_rx, 1);
      chk("simul_rx_word", {16'd0, rx_log[b_rx % 256]}, 32'h6B2D);
      chk("simul_no_ferr", n_fe - b_fe, 0);
      chk("simul_miso_word", {16'd0, mi_w[0]}, 32'h0F1E);

      for (int r = 0; r < 8; r++) begin
         idle_noise(int'($urandom_range(5, 20)));
         nw = int'($urandom_range(1, 3));
         for (int j = 0; j < 4; j++) begin
            mo_w[j] = 16'($urandom);
            so_w[j] = 16'($urandom);
         end
         run_and_check("random", nw);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
